// File: rtl/wb_commit_queue.sv
// Writeback commit stage: combinational register/segment write strobes plus an
// in-order store queue that drains to the D-cache over a valid/ready handshake.
module wb_commit_queue #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 32,
   parameter int MQ_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             valid_in,
   input  logic [NUM_CH*DATA_W-1:0]         ch_data,
   input  logic [NUM_CH*ADDR_W-1:0]         ch_dest,
   input  logic [NUM_CH-1:0]                ch_is_reg,
   input  logic [NUM_CH-1:0]                ch_is_seg,
   input  logic [NUM_CH-1:0]                ch_is_mem,
   input  logic [NUM_CH-1:0]                ch_wb,
   input  logic [1:0]                       size_in,
   input  logic                             br_correct_in,
   input  logic                             ie_in,
   input  logic                             interrupt_in,
   input  logic                             mem_ready,
   output logic                             valid_out,
   output logic                             stall,
   output logic [NUM_CH-1:0]                reg_ld,
   output logic [NUM_CH-1:0]                seg_ld,
   output logic [3*NUM_CH-1:0]              wb_addr,
   output logic [NUM_CH*DATA_W-1:0]         wb_data,
   output logic                             mem_valid,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic [DATA_W-1:0]                mem_data,
   output logic [1:0]                       mem_size,
   output logic [$clog2(MQ_DEPTH+1)-1:0]    mq_count,
   output logic                             is_resteer,
   output logic                             final_ie_val,
   output logic                             final_ie_int
);

   localparam int CNT_W = $clog2(MQ_DEPTH + 1);
   localparam int PTR_W = (MQ_DEPTH > 1) ? $clog2(MQ_DEPTH) : 1;

   logic [ADDR_W-1:0] mqAddr_q [MQ_DEPTH];
   logic [ADDR_W-1:0] mqAddr_d [MQ_DEPTH];
   logic [DATA_W-1:0] mqData_q [MQ_DEPTH];
   logic [DATA_W-1:0] mqData_d [MQ_DEPTH];
   logic [1:0]        mqSize_q [MQ_DEPTH];
   logic [1:0]        mqSize_d [MQ_DEPTH];

   logic [PTR_W-1:0]  headPtr_q, headPtr_d;
   logic [PTR_W-1:0]  tailPtr_q, tailPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              resteer_q, resteer_d;

   logic [NUM_CH-1:0] memWr;
   logic [CNT_W-1:0]  nmem;
   logic [CNT_W-1:0]  freeSlots;
   logic [CNT_W-1:0]  enqCount;
   logic              commitClean;
   logic              deq;

   assign memWr = ch_wb & ch_is_mem;

   always_comb begin
      nmem = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         nmem = nmem + {{(CNT_W-1){1'b0}}, memWr[k]};
      end
   end

   // Free space is judged on the registered count only, so a dequeue this
   // cycle cannot rescue a stalled instruction until the next cycle.
   assign freeSlots    = CNT_W'(MQ_DEPTH) - count_q;
   assign stall        = valid_in & (nmem > freeSlots);
   assign valid_out    = valid_in & ~stall;
   assign final_ie_val = valid_in & (ie_in | interrupt_in);
   assign final_ie_int = valid_in & interrupt_in;
   assign commitClean  = valid_out & ~final_ie_val;

   assign reg_ld  = {NUM_CH{commitClean}} & ch_wb & ch_is_reg;
   assign seg_ld  = {NUM_CH{commitClean}} & ch_wb & ch_is_seg;
   assign wb_data = ch_data;

   always_comb begin
      wb_addr = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         wb_addr[3*k +: 3] = ch_dest[k*ADDR_W +: 3];
      end
   end

   assign mem_valid = (count_q != '0);
   assign deq       = mem_valid & mem_ready;
   assign mem_addr  = mqAddr_q[headPtr_q];
   assign mem_data  = mqData_q[headPtr_q];
   assign mem_size  = mqSize_q[headPtr_q];
   assign mq_count  = count_q;
   assign is_resteer = resteer_q;

   assign enqCount = commitClean ? nmem : '0;

   // Memory channels pack into consecutive tail slots in ascending channel
   // order; the running offset skips channels that carry no store.
   always_comb begin
      int unsigned ofs;
      logic [PTR_W-1:0] slot;
      mqAddr_d = mqAddr_q;
      mqData_d = mqData_q;
      mqSize_d = mqSize_q;
      ofs      = 0;
      slot     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (commitClean && memWr[k]) begin
            slot = PTR_W'((int'(tailPtr_q) + ofs) % MQ_DEPTH);
            mqAddr_d[slot] = ch_dest[k*ADDR_W +: ADDR_W];
            mqData_d[slot] = ch_data[k*DATA_W +: DATA_W];
            mqSize_d[slot] = size_in;
            ofs = ofs + 1;
         end
      end
   end

   always_comb begin
      tailPtr_d = PTR_W'((int'(tailPtr_q) + int'(enqCount)) % MQ_DEPTH);
      headPtr_d = deq ? PTR_W'((int'(headPtr_q) + 1) % MQ_DEPTH) : headPtr_q;
      count_d   = count_q + enqCount - {{(CNT_W-1){1'b0}}, deq};
      resteer_d = valid_out & ~br_correct_in & ~final_ie_val;
   end

   // Reset discards every pending store along with the pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         headPtr_q <= '0;
         tailPtr_q <= '0;
         count_q   <= '0;
         resteer_q <= 1'b0;
         for (int i = 0; i < MQ_DEPTH; i++) begin
            mqAddr_q[i] <= '0;
            mqData_q[i] <= '0;
            mqSize_q[i] <= '0;
         end
      end else begin
         headPtr_q <= headPtr_d;
         tailPtr_q <= tailPtr_d;
         count_q   <= count_d;
         resteer_q <= resteer_d;
         mqAddr_q  <= mqAddr_d;
         mqData_q  <= mqData_d;
         mqSize_q  <= mqSize_d;
      end
   end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the commit and store-drain rules.
module tb_wb_commit_queue;

   localparam int NUM_CH   = 4;
   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 32;
   localparam int MQ_DEPTH = 8;
   localparam int CNT_W    = $clog2(MQ_DEPTH + 1);

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [1:0]        size;
   } entry_t;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        valid_in;
   logic [NUM_CH*DATA_W-1:0]    ch_data;
   logic [NUM_CH*ADDR_W-1:0]    ch_dest;
   logic [NUM_CH-1:0]           ch_is_reg, ch_is_seg, ch_is_mem, ch_wb;
   logic [1:0]                  size_in;
   logic                        br_correct_in, ie_in, interrupt_in, mem_ready;
   logic                        valid_out, stall, mem_valid, is_resteer;
   logic                        final_ie_val, final_ie_int;
   logic [NUM_CH-1:0]           reg_ld, seg_ld;
   logic [3*NUM_CH-1:0]         wb_addr;
   logic [NUM_CH*DATA_W-1:0]    wb_data;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_data;
   logic [1:0]                  mem_size;
   logic [CNT_W-1:0]            mq_count;

   entry_t modelQ[$];
   logic   expResteer;
   int     checkCount = 0;
   int     failCount  = 0;

   always #5 clk = ~clk;

   wb_commit_queue #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MQ_DEPTH(MQ_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ch_data(ch_data),
      .ch_dest(ch_dest), .ch_is_reg(ch_is_reg), .ch_is_seg(ch_is_seg),
      .ch_is_mem(ch_is_mem), .ch_wb(ch_wb), .size_in(size_in),
      .br_correct_in(br_correct_in), .ie_in(ie_in), .interrupt_in(interrupt_in),
      .mem_ready(mem_ready), .valid_out(valid_out), .stall(stall),
      .reg_ld(reg_ld), .seg_ld(seg_ld), .wb_addr(wb_addr), .wb_data(wb_data),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_size(mem_size), .mq_count(mq_count), .is_resteer(is_resteer),
      .final_ie_val(final_ie_val), .final_ie_int(final_ie_int)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearInputs();
      valid_in      = 1'b0;
      ch_data       = '0;
      ch_dest       = '0;
      ch_is_reg     = '0;
      ch_is_seg     = '0;
      ch_is_mem     = '0;
      ch_wb         = '0;
      size_in       = 2'd0;
      br_correct_in = 1'b1;
      ie_in         = 1'b0;
      interrupt_in  = 1'b0;
      mem_ready     = 1'b0;
   endtask

   // cls: 0 none, 1 register, 2 segment, 3 memory
   task automatic setChannel(input int k, input int cls, input logic wb,
                             input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data);
      ch_is_reg[k] = (cls == 1);
      ch_is_seg[k] = (cls == 2);
      ch_is_mem[k] = (cls == 3);
      ch_wb[k]     = wb;
      ch_dest[k*ADDR_W +: ADDR_W] = dest;
      ch_data[k*DATA_W +: DATA_W] = data;
   endtask

   task automatic applyStimulus(input int readyPct);
      int r;
      valid_in = ($urandom_range(0, 99) < 80);
      for (int k = 0; k < NUM_CH; k++) begin
         r = $urandom_range(0, 5);
         setChannel(k, (r > 3) ? 3 : r, $urandom_range(0, 7) != 0, $urandom,
                    {$urandom, $urandom});
      end
      size_in       = 2'($urandom_range(0, 3));
      br_correct_in = ($urandom_range(0, 3) != 0);
      ie_in         = ($urandom_range(0, 15) == 0);
      interrupt_in  = ($urandom_range(0, 15) == 0);
      mem_ready     = ($urandom_range(0, 99) < readyPct);
   endtask

   // Called just after a falling edge with inputs already driven; checks all
   // outputs against the model, then advances the model across the rising edge.
   task automatic runCycle();
      int nmem;
      logic fault, expStall, commit, clean, doDeq;
      logic [NUM_CH-1:0] expReg, expSeg;
      logic [3*NUM_CH-1:0] expAddr;
      entry_t e;
      #1;
      nmem = 0;
      for (int k = 0; k < NUM_CH; k++)
         if (ch_wb[k] && ch_is_mem[k]) nmem++;
      fault    = valid_in && (ie_in || interrupt_in);
      expStall = valid_in && (nmem > MQ_DEPTH - modelQ.size());
      commit   = valid_in && !expStall;
      clean    = commit && !fault;
      for (int k = 0; k < NUM_CH; k++) begin
         expReg[k] = clean && ch_wb[k] && ch_is_reg[k];
         expSeg[k] = clean && ch_wb[k] && ch_is_seg[k];
         expAddr[3*k +: 3] = ch_dest[k*ADDR_W +: 3];
         checkOutput("wb_data", wb_data[k*DATA_W +: DATA_W], ch_data[k*DATA_W +: DATA_W]);
      end
      checkOutput("stall", stall, expStall);
      checkOutput("valid_out", valid_out, commit);
      checkOutput("reg_ld", reg_ld, expReg);
      checkOutput("seg_ld", seg_ld, expSeg);
      checkOutput("wb_addr", wb_addr, expAddr);
      checkOutput("final_ie_val", final_ie_val, fault);
      checkOutput("final_ie_int", final_ie_int, valid_in && interrupt_in);
      checkOutput("mq_count", mq_count, modelQ.size());
      checkOutput("mem_valid", mem_valid, modelQ.size() != 0);
      checkOutput("is_resteer", is_resteer, expResteer);
      if (modelQ.size() != 0) begin
         checkOutput("mem_addr", mem_addr, modelQ[0].addr);
         checkOutput("mem_data", mem_data, modelQ[0].data);
         checkOutput("mem_size", mem_size, modelQ[0].size);
      end
      doDeq = (modelQ.size() != 0) && mem_ready;
      @(posedge clk);
      if (doDeq) void'(modelQ.pop_front());
      if (clean) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_wb[k] && ch_is_mem[k]) begin
               e.addr = ch_dest[k*ADDR_W +: ADDR_W];
               e.data = ch_data[k*DATA_W +: DATA_W];
               e.size = size_in;
               modelQ.push_back(e);
            end
         end
      end
      expResteer = commit && !br_correct_in && !fault;
      @(negedge clk);
   endtask

   task automatic doReset();
      clearInputs();
      rst = 1'b0;
      #1;
      checkOutput("rst_mq_count", mq_count, 0);
      checkOutput("rst_mem_valid", mem_valid, 0);
      checkOutput("rst_is_resteer", is_resteer, 0);
      modelQ.delete();
      expResteer = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int readyPct;
      rst = 1'b1;
      expResteer = 1'b0;
      clearInputs();
      @(negedge clk);
      doReset();

      // Reset then a mixed reg + mem instruction
      valid_in = 1'b1;
      size_in  = 2'd3;
      setChannel(0, 1, 1'b1, 32'd3, 64'h1111);
      setChannel(1, 3, 1'b1, 32'h1000, 64'hAB);
      #1;
      checkOutput("t1_reg_ld", reg_ld, 4'b0001);
      checkOutput("t1_wb_addr0", wb_addr[2:0], 3'd3);
      runCycle();
      clearInputs();
      #1;
      checkOutput("t1_mem_valid", mem_valid, 1);
      checkOutput("t1_mem_addr", mem_addr, 32'h1000);
      checkOutput("t1_mem_data", mem_data, 64'hAB);
      runCycle();

      // Fill the queue, then stall until a dequeue frees room
      doReset();
      for (int i = 0; i < 2; i++) begin
         clearInputs();
         valid_in = 1'b1;
         for (int k = 0; k < NUM_CH; k++)
            setChannel(k, 3, 1'b1, 32'h2000 + 32'(i * 16 + k * 4), 64'(i * 100 + k));
         runCycle();
      end
      clearInputs();
      valid_in = 1'b1;
      setChannel(0, 3, 1'b1, 32'h3000, 64'hC0FFEE);
      setChannel(1, 1, 1'b1, 32'd5, 64'h55);
      #1;
      checkOutput("t2_mq_full", mq_count, 8);
      checkOutput("t2_stall", stall, 1);
      checkOutput("t2_valid_out", valid_out, 0);
      checkOutput("t2_reg_ld", reg_ld, 0);
      runCycle();
      runCycle();
      mem_ready = 1'b1;
      #1;
      checkOutput("t2_stall_deq_cycle", stall, 1);
      runCycle();
      #1;
      checkOutput("t2_stall_released", stall, 0);
      runCycle();
      clearInputs();
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) runCycle();

      // Misprediction pulses, single and back-to-back
      clearInputs();
      valid_in = 1'b1;
      br_correct_in = 1'b0;
      runCycle();
      clearInputs();
      #1;
      checkOutput("t4_pulse", is_resteer, 1);
      runCycle();
      #1;
      checkOutput("t4_pulse_end", is_resteer, 0);
      valid_in = 1'b1;
      br_correct_in = 1'b0;
      runCycle();
      runCycle();
      clearInputs();
      #1;
      checkOutput("t4_b2b_pulse", is_resteer, 1);
      runCycle();

      // Interrupt suppresses writes, enqueue and resteer
      doReset();
      valid_in = 1'b1;
      interrupt_in = 1'b1;
      br_correct_in = 1'b0;
      setChannel(0, 1, 1'b1, 32'd2, 64'h77);
      setChannel(1, 3, 1'b1, 32'h4000, 64'h88);
      #1;
      checkOutput("t5_ie_val", final_ie_val, 1);
      checkOutput("t5_ie_int", final_ie_int, 1);
      checkOutput("t5_valid_out", valid_out, 1);
      checkOutput("t5_reg_ld", reg_ld, 0);
      runCycle();
      clearInputs();
      #1;
      checkOutput("t5_no_enq", mq_count, 0);
      checkOutput("t5_no_resteer", is_resteer, 0);
      runCycle();

      // Randomized traffic with varying drain rates and mid-run resets
      for (int c = 0; c < 800; c++) begin
         case (c / 200)
            0: readyPct = 30;
            1: readyPct = 85;
            2: readyPct = 5;
            default: readyPct = 50;
         endcase
         if (c % 200 == 150) doReset();
         else begin
            applyStimulus(readyPct);
            runCycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Parametrised next-generation writeback commit stage. It accepts one retiring instruction per cycle carrying up to NUM_CH result channels and commits them:
- register and segment writes go out combinationally;
- memory writes go into a small in-order store queue that drains to the data cache over a valid/ready handshake.

The block generates the writeback stall, a registered single-cycle resteer pulse and the final exception/interrupt indication. It sits between the execute-stage latches and the register file, segment file and D-cache write port.

## Interface
Parameters:
- NUM_CH, 4, result channels per instruction (1..8)
- DATA_W, 64, result data width
- ADDR_W, 32, destination width (register/segment index in bits [2:0], memory address otherwise)
- MQ_DEPTH, 8, store-queue entries (power of two, ≥ NUM_CH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- valid_in  in  1  instruction present at writeback
- ch_data  in  NUM_CH*DATA_W  channel results, channel 0 in LSBs
- ch_dest  in  NUM_CH*ADDR_W  channel destinations
- ch_is_reg, ch_is_seg, ch_is_mem  in  NUM_CH each  destination-class one-hots per channel
- ch_wb  in  NUM_CH  channel write enable
- size_in  in  2  operand size code
- br_correct_in  in  1  branch prediction correct (1 for non-branches)
- ie_in  in  1  exception from earlier stages
- interrupt_in  in  1  external interrupt
- mem_ready  in  1  D-cache accepts the queue head
- valid_out  out  1  instruction committed this cycle
- stall  out  1  writeback cannot accept; upstream holds
- reg_ld, seg_ld  out  NUM_CH each  per-channel load strobes
- wb_addr  out  3*NUM_CH  per-channel register/segment index (ch_dest[2:0] per channel)
- wb_data  out  NUM_CH*DATA_W  pass-through of ch_data
- mem_valid  out  1  queue head valid
- mem_addr  out  ADDR_W  head address
- mem_data  out  DATA_W  head data
- mem_size  out  2  head size code
- mq_count  out  clog2(MQ_DEPTH+1)  occupied entries
- is_resteer  out  1  registered mispredict pulse
- final_ie_val  out  1  exception or interrupt at this instruction
- final_ie_int  out  1  the event is an interrupt

## Operation
- **Channel write.** Channel k wants a write when ch_wb[k] is set and one of its class bits is set. nmem = popcount over channels of (ch_wb & ch_is_mem).
- **Exception.** final_ie_val = valid_in & (ie_in | interrupt_in). final_ie_int = valid_in & interrupt_in.
- **Stall.** stall = valid_in & (nmem > MQ_DEPTH − mq_count). Free space comes from the registered count only; there is no credit from a same-cycle dequeue.
- **Commit.** valid_out = valid_in & ~stall. A faulting instruction (final_ie_val=1) still commits but suppresses all of its writes.
- **Write strobes.** reg_ld[k] = valid_out & ~final_ie_val & ch_wb[k] & ch_is_reg[k]; seg_ld has the same form.
- **Enqueue.** On commit without fault, the memory channels are written into the queue in ascending channel order at consecutive tail slots, all in the same cycle. Each entry is {addr, data, size_in}.
- **Dequeue.** The head leaves when mem_valid & mem_ready. mem_valid = (mq_count ≠ 0).
- **Queue pointers.** Head and tail pointers wrap modulo MQ_DEPTH. mq_count_next = mq_count + enq − deq. Enqueue and dequeue in the same cycle are legal.
- **Resteer.** is_resteer_next = valid_out & ~br_correct_in & ~final_ie_val. It is high for exactly one cycle after the commit.

## Timing
- **Reset.** Asserting rst low immediately clears the queue, pointers, mq_count and is_resteer, so mem_valid=0. All combinational outputs follow the inputs. Asserting reset mid-drain discards all pending stores.
- **Combinational paths.** Stall, valid_out, the strobes and final_ie_* are combinational in the current cycle.
- **Enqueue latency.** An enqueued store is visible on mem_* one cycle after commit, at the earliest.
- **Full queue.** While the queue is full, an instruction with nmem ≥ 1 stalls. An instruction with nmem=0 commits.
- **Empty queue.** mem_ready is ignored.
- **Dequeue and stall.** A dequeue in a stall cycle frees space only from the next cycle.
- **Resteer back-to-back.** Back-to-back mispredicts produce back-to-back pulses.

## Test plan
1. **Reset.** Reset with valid_in=0 → mq_count=0, mem_valid=0, is_resteer=0. Then one instruction, channel 0 reg dest 3, channel 1 mem addr 0x1000 data 0xAB → reg_ld=0001, wb_addr[2:0]=3, next cycle mem_valid=1, mem_addr=0x1000, mem_data=0xAB.
2. **Fill and stall.** With mem_ready=0 and MQ_DEPTH=8, commit two instructions with 4 mem channels each → mq_count=8. A third instruction with 1 mem write → stall=1, valid_out=0, reg_ld=0. It stays stalled while mem_ready=0; raise mem_ready → stall drops the cycle after the first dequeue.
3. **Simultaneous enqueue and dequeue, wrap.** mq_count=7 with tail at slot 7; enqueue 1 while dequeuing 1 → count stays 7, tail wraps to 0. Drain order matches channel/commit order.
4. **Misprediction.** Commit with br_correct_in=0 → is_resteer=1 for exactly the next cycle. br_correct_in=0 while stalled → no pulse until the instruction commits.
5. **Exception/interrupt.** valid_in=1, interrupt_in=1, channels with reg and mem writes → final_ie_val=1, final_ie_int=1, valid_out=1, reg_ld=0, no enqueue, no resteer.
6. **Reset mid-operation.** Assert rst low with mq_count=5 → mem_valid=0 and count=0 immediately. After release, new stores enqueue starting from slot 0.
